// File: rtl/stream_dot_prod.sv
// Streaming dot product: multiply, reduce and accumulate stages with valid/ready
// on both sides; one LEN-element vector pair accepted per beat.
module stream_dot_prod #(
    parameter int N     = 32,
    parameter int LEN   = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a [LEN-1:0],
    input  logic [N-1:0]     in_b [LEN-1:0],
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic [CNT_W-1:0] out_count
);

    // Leaves padded up to a power of two so the tree stays balanced
    localparam int P = 1 << $clog2(LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             adv;
    logic [N-1:0]     prod [P];
    logic [N-1:0]     p    [P];
    logic [N-1:0]     tree [2*P-1];
    logic             s1_valid, s1_last;
    logic             s2_valid, s2_last;
    logic [N-1:0]     s2_sum;
    logic [N-1:0]     acc;
    logic [CNT_W-1:0] cnt;
    logic             first;
    logic [N-1:0]     total;
    logic [CNT_W-1:0] base_cnt;
    logic [CNT_W-1:0] cnt_new;

    assign adv      = ~(out_valid & ~out_ready);
    assign in_ready = adv;

    always_comb begin
        for (int i = 0; i < LEN; i++) prod[i] = in_a[i] * in_b[i];
        for (int i = LEN; i < P; i++) prod[i] = '0;
    end

    always_comb begin
        for (int k = 0; k < P; k++) tree[P-1+k] = p[k];
        for (int k = P - 2; k >= 0; k--) tree[k] = tree[2*k+1] + tree[2*k+2];
    end

    always_comb begin
        total    = (first ? '0 : acc) + s2_sum;
        base_cnt = first ? '0 : cnt;
        cnt_new  = (base_cnt == CNT_MAX) ? CNT_MAX : base_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            for (int i = 0; i < P; i++) p[i] <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_last  <= in_last;
            for (int i = 0; i < P; i++) p[i] <= prod[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_sum   <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_sum   <= tree[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            cnt       <= '0;
            first     <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else if (adv) begin
            // Unstalled with out_valid set means the result is taken now
            if (out_valid) out_valid <= 1'b0;
            if (s2_valid) begin
                if (s2_last) begin
                    out_data  <= total;
                    out_count <= cnt_new;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                    first     <= 1'b1;
                end else begin
                    acc   <= total;
                    cnt   <= cnt_new;
                    first <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_dot_prod.sv
// Directed bench for stream_dot_prod: expected results queued at issue time,
// checked by an independent output monitor.
module tb_stream_dot_prod;

    localparam int N  = 32;
    localparam int L  = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a [L-1:0];
    logic [N-1:0]  b [L-1:0];
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic [CW-1:0] out_count;

    typedef struct {
        logic [N-1:0]  data;
        logic [CW-1:0] count;
    } exp_t;

    exp_t exp_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    stream_dot_prod #(.N(N), .LEN(L), .CNT_W(CW)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(a),
        .in_b(b),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [N-1:0] d, input logic [CW-1:0] c);
        exp_t e;
        e.data  = d;
        e.count = c;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [N-1:0] a0, a1, a2, a3,
                        input logic [N-1:0] b0, b1, b2, b3,
                        input logic l);
        int w;
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        in_last  = l;
        in_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready stuck at 0, required 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: every transferred result must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got data %0h count %0d, required none",
                         out_data, out_count);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_data", 64'(out_data), 64'(e.data));
                chk("out_count", 64'(out_count), 64'(e.count));
            end
        end
    end

    initial begin
        int w;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < L; i++) begin
            a[i] = '0;
            b[i] = '0;
        end
        repeat (2) step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        step();

        // Single beat with latency probe
        push(32'd70, 2'd1);
        send(1, 2, 3, 4, 5, 6, 7, 8, 1'b1);
        chk("lat_e0", 64'(out_valid), 64'd0);
        step();
        chk("lat_e1", 64'(out_valid), 64'd0);
        step();
        chk("lat_e2", 64'(out_valid), 64'd1);
        repeat (4) step();

        // Two-beat accumulation, back to back
        send(1, 2, 3, 4, 5, 6, 7, 8, 1'b0);
        push(32'd74, 2'd2);
        send(1, 1, 1, 1, 1, 1, 1, 1, 1'b1);
        repeat (5) step();

        // Wraparound with negative operand
        push(32'hFFFF_FFFD, 2'd1);
        send(32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 2, 3, 0, 0, 1'b1);
        repeat (5) step();

        // Reset while a partial sum is in flight
        send(1, 2, 3, 4, 5, 6, 7, 8, 1'b0);
        step();
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", 64'(out_data), 64'd0);
        chk("mid_rst_count", 64'(out_count), 64'd0);
        step();
        reset = 1'b0;
        step();
        push(32'd9, 2'd1);
        send(1, 0, 0, 0, 9, 0, 0, 0, 1'b1);
        repeat (5) step();

        // Backpressure: three results queue behind a stalled output
        out_ready = 1'b0;
        push(32'd70, 2'd1);
        send(1, 2, 3, 4, 5, 6, 7, 8, 1'b1);
        push(32'd4, 2'd1);
        send(1, 1, 1, 1, 1, 1, 1, 1, 1'b1);
        push(32'd0, 2'd1);
        send(0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
        repeat (4) step();
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_out_data", 64'(out_data), 64'd70);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_queued", 64'(exp_q.size()), 64'd3);
        out_ready = 1'b1;
        repeat (3) step();
        chk("bp_drained", 64'(exp_q.size()), 64'd0);
        chk("bp_idle", 64'(out_valid), 64'd0);
        repeat (2) step();

        // Beat counter saturation at 3 with a 2-bit counter
        for (int i = 0; i < 4; i++) send(1, 0, 0, 0, 1, 0, 0, 0, 1'b0);
        push(32'd5, 2'd3);
        send(1, 0, 0, 0, 1, 0, 0, 0, 1'b1);

        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            step();
            w++;
        end
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
